// File: rtl/counter_sequencer.sv
// Run controller for a prescaled up-counter: holds the run configuration and
// sequences IDLE/RUN/HOLD/DONE, emitting the count, busy, done and cfg_err.
module counter_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  periodic_q, periodic_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cfg_open;

  assign cfg_open = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
    end else begin
      // A rejected write mid-run only flags the error; counting carries on.
      if (cfg_we) begin
        if (cfg_open) begin
          limit_d    = cfg_limit;
          prescale_d = cfg_prescale;
          periodic_d = cfg_periodic;
        end else begin
          err_d = 1'b1;
        end
      end

      if (start) begin
        state_d = RUN;
        count_d = '0;
        psc_d   = '0;
      end else begin
        case (state_q)
          RUN: begin
            if (hold) begin
              state_d = HOLD;
            end else if (psc_q == prescale_q) begin
              psc_d = '0;
              // Terminal check precedes the increment, so count never passes the limit.
              if (count_q == limit_q) begin
                done_d = 1'b1;
                if (periodic_q) count_d = '0;
                else            state_d = DONE;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              psc_d = psc_q + PRESCALE_W'(1);
            end
          end
          HOLD: begin
            if (!hold) state_d = RUN;
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d == RUN) || (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= '1;
      prescale_q <= '0;
      psc_q      <= '0;
      periodic_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      periodic_q <= periodic_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, directed corner sequences and
// randomized traffic against a tick-arithmetic reference model.
module tb_counter_sequencer;
  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we, cfg_periodic, start, stop, hold;
  logic [WIDTH-1:0] cfg_limit;
  logic [PW-1:0]    cfg_prescale;
  logic [WIDTH-1:0] count;
  logic             busy, done, cfg_err;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
    .cfg_prescale(cfg_prescale), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .hold(hold),
    .count(count), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the count is derived from the number of active run cycles.
  int m_phase;   // 0 idle, 1 running (incl. held), 2 finished
  bit m_held;
  int m_act, m_lim, m_pre, m_frozen;
  bit m_per, m_done, m_err;

  task automatic model_reset();
    m_phase = 0; m_held = 0; m_act = 0; m_frozen = 0;
    m_lim = 255; m_pre = 0; m_per = 0; m_done = 0; m_err = 0;
  endtask

  function automatic int model_count();
    int k;
    if (m_phase != 1) return m_frozen;
    k = m_act / (m_pre + 1);
    return m_per ? (k % (m_lim + 1)) : k;
  endfunction

  task automatic model_step(input bit we, input int lim, input int pre, input bit per,
                            input bit st, input bit sp, input bit hd);
    m_done = 0;
    m_err  = 0;
    if (sp) begin
      m_phase = 0; m_frozen = 0; m_held = 0;
    end else begin
      if (we) begin
        if (m_phase == 1) m_err = 1;
        else begin m_lim = lim; m_pre = pre; m_per = per; end
      end
      if (st) begin
        m_phase = 1; m_act = 0; m_held = 0;
      end else if (m_phase == 1) begin
        if (m_held) begin
          if (!hd) m_held = 0;
        end else if (hd) begin
          m_held = 1;
        end else begin
          m_act++;
          if ((m_act % (m_pre + 1) == 0) && ((m_act / (m_pre + 1)) % (m_lim + 1) == 0)) begin
            m_done = 1;
            if (!m_per) begin m_phase = 2; m_frozen = m_lim; end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input int c, input bit b, input bit d, input bit e);
    n_vec++;
    if (count !== WIDTH'(c) || busy !== b || done !== d || cfg_err !== e) begin
      n_bad++;
      $display("FAIL %s: got count=%0d busy=%b done=%b cfg_err=%b, want count=%0d busy=%b done=%b cfg_err=%b",
               name, count, busy, done, cfg_err, c, b, d, e);
    end
  endtask

  task automatic check_model(input string name);
    check(name, model_count(), m_phase == 1, m_done, m_err);
  endtask

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic drive(input bit we, input int lim, input int pre, input bit per,
                       input bit st, input bit sp, input bit hd);
    cfg_we = we; cfg_limit = WIDTH'(lim); cfg_prescale = PW'(pre); cfg_periodic = per;
    start = st; stop = sp; hold = hd;
    @(posedge clk);
    #1;
    model_step(we, lim, pre, per, st, sp, hd);
  endtask

  typedef struct {
    bit we; int lim; int pre; bit per; bit st; bit sp; bit hd;
    int c; bit b; bit d; bit e;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit we, input int lim, input int pre, input bit per,
                     input bit st, input bit sp, input bit hd,
                     input int c, input bit b, input bit d, input bit e);
    vec_t v;
    v.we = we; v.lim = lim; v.pre = pre; v.per = per; v.st = st; v.sp = sp; v.hd = hd;
    v.c = c; v.b = b; v.d = d; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    int ndone;
    reset = 1'b0;
    cfg_we = 0; cfg_limit = '0; cfg_prescale = '0; cfg_periodic = 0;
    start = 0; stop = 0; hold = 0;
    model_reset();

    // One-shot limit 5, then a limit-10 run with a rejected write and stop+start.
    add(1, 5, 0, 0, 1, 0, 0,  0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 0, 0, i, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  5, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,  5, 0, 0, 0);
    add(1, 10, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 0, 0, 0, i, 1, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0,  8, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,  9, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 10, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 10, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].lim, tbl[i].pre, tbl[i].per, tbl[i].st, tbl[i].sp, tbl[i].hd);
      check($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].e);
    end

    // Periodic limit 3 prescale 2: 12-cycle period, two done pulses in 24 cycles.
    drive(1, 3, 2, 1, 1, 0, 0);
    check("per_start", 0, 1, 0, 0);
    ndone = 0;
    for (int i = 1; i <= 24; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check_model($sformatf("per_c%0d", i));
      ndone += int'(done);
    end
    n_vec++;
    if (ndone != 2) begin
      n_bad++;
      $display("FAIL per_done_count: got %0d pulses, want 2", ndone);
    end

    // Hold at count 4 for six cycles, then resume to done at 10.
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 10, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 0, 0, 0, 0, 0);
    check("hold_pre", 4, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      check($sformatf("hold_h%0d", i), 4, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hold_release", 4, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hold_resume", 5, 1, 0, 0);
    for (int i = 6; i <= 11; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check_model($sformatf("hold_run%0d", i));
    end
    check("hold_done", 10, 0, 1, 0);

    // Limit 0 periodic: done every tick, restart gives no done on the start edge.
    drive(1, 0, 0, 1, 1, 0, 0);
    check("l0_start", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("l0_tick%0d", i), 0, 1, 1, 0);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    check("l0_restart", 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("l0_after", 0, 1, 1, 0);

    // Asynchronous reset between edges, then default limit 255 run.
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 20, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 6; i++) drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_pre", 6, 1, 0, 0);
    #3 reset = 1'b0;
    #1;
    check("rst_async", 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 255; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (i % 51 == 0) check_model($sformatf("r255_c%0d", i));
    end
    check("r255_top", 255, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("r255_done", 255, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(7) == 0, $urandom_range(12), $urandom_range(3),
            $urandom_range(1) == 1, $urandom_range(15) == 0, $urandom_range(31) == 0,
            $urandom_range(3) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
